// File: rtl/hazard_scoreboard.sv
// Hazard unit plus one-deep multi-cycle scoreboard; optional stall/flush counters via HAZARD_SCOREBOARD_PERF_EN.
// Latency: forwarding/stall/flush are combinational; mc_busy/mc_done/mc_rd update one edge after the cause.
// Backpressure: no handshake; stall_f/stall_d hold upstream stages, and an issue into a busy unit is dropped.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 4,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              mc_op_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              load_e,
    input  logic              pcsrc_e,
    input  logic              mc_start_e,
    input  logic [LAT_W-1:0]  mc_lat_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mc_busy,
    output logic              mc_done,
`ifdef HAZARD_SCOREBOARD_PERF_EN
    output logic [REG_AW-1:0] mc_rd,
    output logic [PERF_W-1:0] perf_lu,
    output logic [PERF_W-1:0] perf_sb,
    output logic [PERF_W-1:0] perf_fl
`else
    output logic [REG_AW-1:0] mc_rd
`endif
);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic              mc_busy_q, mc_busy_d;
    logic              mc_done_q, mc_done_d;
    logic [LAT_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [REG_AW-1:0] mc_rd_q, mc_rd_d;

    logic              lu_stall;
    logic              sb_stall;
    logic              any_stall;
    logic              cnt_is_one;
    logic              mc_accept;
    logic [LAT_W-1:0]  lat_eff;

    // Memory-stage result is younger than writeback, so it wins on a double match.
    always_comb begin
        fwd_a_e = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs1_e)) begin
            fwd_a_e = FWD_MEM;
        end else if (regwrite_w && (rd_w != '0) && (rd_w == rs1_e)) begin
            fwd_a_e = FWD_WB;
        end
    end

    always_comb begin
        fwd_b_e = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs2_e)) begin
            fwd_b_e = FWD_MEM;
        end else if (regwrite_w && (rd_w != '0) && (rd_w == rs2_e)) begin
            fwd_b_e = FWD_WB;
        end
    end

    // An x0 destination occupies the unit but never causes a RAW/WAW match.
    always_comb begin
        lu_stall  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        sb_stall  = mc_busy_q &&
                    (((mc_rd_q != '0) && ((mc_rd_q == rs1_d) || (mc_rd_q == rs2_d))) ||
                     (regwrite_d && (mc_rd_q != '0) && (rd_d == mc_rd_q)) ||
                     mc_op_d);
        any_stall = lu_stall || sb_stall;
        stall_f   = any_stall && !pcsrc_e;
        stall_d   = any_stall && !pcsrc_e;
        flush_d   = pcsrc_e;
        flush_e   = pcsrc_e || any_stall;
    end

    // A new issue is only taken when idle or in the final count cycle of the current op.
    always_comb begin
        cnt_is_one = (mc_cnt_q == LAT_W'(1));
        lat_eff    = (mc_lat_e == '0) ? LAT_W'(1) : mc_lat_e;
        mc_accept  = mc_start_e && (!mc_busy_q || cnt_is_one);
        mc_done_d  = mc_busy_q && cnt_is_one;
        mc_busy_d  = mc_busy_q;
        mc_cnt_d   = mc_cnt_q;
        mc_rd_d    = mc_rd_q;
        if (mc_accept) begin
            mc_busy_d = 1'b1;
            mc_cnt_d  = lat_eff;
            mc_rd_d   = rd_e;
        end else if (mc_busy_q) begin
            if (cnt_is_one) begin
                mc_busy_d = 1'b0;
                mc_cnt_d  = '0;
            end else begin
                mc_cnt_d  = mc_cnt_q - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_busy_q <= 1'b0;
            mc_done_q <= 1'b0;
            mc_cnt_q  <= '0;
            mc_rd_q   <= '0;
        end else begin
            mc_busy_q <= mc_busy_d;
            mc_done_q <= mc_done_d;
            mc_cnt_q  <= mc_cnt_d;
            mc_rd_q   <= mc_rd_d;
        end
    end

    assign mc_busy = mc_busy_q;
    assign mc_done = mc_done_q;
    assign mc_rd   = mc_rd_q;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
    logic [PERF_W-1:0] perf_sb_q, perf_sb_d;
    logic [PERF_W-1:0] perf_fl_q, perf_fl_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_sb_d = perf_sb_q;
        perf_fl_d = perf_fl_q;
        if (lu_stall && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + PERF_W'(1);
        if (sb_stall && (perf_sb_q != '1)) perf_sb_d = perf_sb_q + PERF_W'(1);
        if (pcsrc_e && (perf_fl_q != '1))  perf_fl_d = perf_fl_q + PERF_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_q <= '0;
            perf_sb_q <= '0;
            perf_fl_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_sb_q <= perf_sb_d;
            perf_fl_q <= perf_fl_d;
        end
    end

    assign perf_lu = perf_lu_q;
    assign perf_sb = perf_sb_q;
    assign perf_fl = perf_fl_q;
`endif

endmodule
